// File: rtl/gpio_spi_bridge_if.sv
// Bus bundle between an SPI host / GPIO register and the SPI-to-GPIO bridge.
// The slave modport is the bridge side; the master modport is the host/register side.
interface gpio_spi_bridge_if;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] rdata;
  logic       we;
  logic [7:0] wdata;
  logic       frame_err;
  logic       busy;

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, rdata,
    output spi_miso, spi_miso_oe, we, wdata, frame_err, busy
  );

  modport master (
    output spi_sck, spi_cs_n, spi_mosi, rdata,
    input  spi_miso, spi_miso_oe, we, wdata, frame_err, busy
  );
endinterface

// File: rtl/gpio_spi_bridge.sv
// SPI mode-0 slave that converts 16-bit frames (command byte, data byte) into
// writes of the 8-bit GPIO register, or shifts the register readback out on MISO.
module gpio_spi_bridge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  gpio_spi_bridge_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCmd, StData, StDone} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_hist_q, sck_hist_d;
  logic                   cs_hist_q, cs_hist_d;
  // Marks when the cs_n chain holds only post-reset samples.
  logic [SYNC_STAGES:0]   vld_q, vld_d;
  // Set once cs_n has been seen high after reset; a frame needs a fresh cs_n fall.
  logic                   armed_q, armed_d;
  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [6:0]             rx_q, rx_d;
  logic [7:0]             tx_q, tx_d;
  logic [7:0]             cmd_q, cmd_d;
  logic                   we_q, we_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   miso_q, miso_d;
  logic                   err_q, err_d;

  logic       sck_s, cs_s, mosi_s;
  logic       sck_rise, sck_fall, cs_fall;
  logic [7:0] rx_next;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_hist_q;
  assign sck_fall = ~sck_s & sck_hist_q;
  assign cs_fall  = ~cs_s & cs_hist_q;
  assign rx_next  = {rx_q, mosi_s};

  // Next-state: synchronisers, edge history and the frame FSM.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
    sck_hist_d  = sck_s;
    cs_hist_d   = cs_s;
    vld_d       = {vld_q[SYNC_STAGES-1:0], 1'b1};
    armed_d     = armed_q | (vld_q[SYNC_STAGES] & cs_s);
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    cmd_d       = cmd_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (armed_q && cs_fall) begin
          state_d = StCmd;
          cnt_d   = 4'd0;
          rx_d    = 7'd0;
        end
      end
      StCmd: begin
        // cs_n high beats any same-cycle sck edge.
        if (cs_s) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (sck_rise) begin
          rx_d  = rx_next[6:0];
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cmd_d   = rx_next;
            tx_d    = (rx_next == 8'h00) ? bus.rdata : 8'h00;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (cs_s) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          // The fall right after the 8th rise must not shift: tx[7] is still unsampled.
          if (sck_fall && cnt_q >= 4'd9) begin
            tx_d = {tx_q[6:0], 1'b0};
          end
          if (sck_rise) begin
            rx_d  = rx_next[6:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_d = StDone;
              if (cmd_q == 8'h80) begin
                we_d    = 1'b1;
                wdata_d = rx_next;
              end
            end
          end
        end
      end
      StDone: begin
        if (cs_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    miso_d = (state_d == StData) ? tx_d[7] : 1'b0;
  end

  // State registers; synchronisers reset to the idle line levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_hist_q  <= 1'b0;
      cs_hist_q   <= 1'b1;
      vld_q       <= '0;
      armed_q     <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'd0;
      cmd_q       <= 8'd0;
      we_q        <= 1'b0;
      wdata_q     <= 8'd0;
      miso_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_hist_q  <= sck_hist_d;
      cs_hist_q   <= cs_hist_d;
      vld_q       <= vld_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      cmd_q       <= cmd_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      miso_q      <= miso_d;
      err_q       <= err_d;
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = ~cs_s;
  assign bus.we          = we_q;
  assign bus.wdata       = wdata_q;
  assign bus.frame_err   = err_q;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_gpio_spi_bridge.sv
// Bench for gpio_spi_bridge: directed table of frames, a reset-mid-frame
// sequence and randomized frames checked against a frame-level model.
module tb_gpio_spi_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpio_spi_bridge_if bus ();

  gpio_spi_bridge #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] rd;
    int         nedges;
    int         exp_we;
    int         exp_err;
    logic [7:0] exp_wdata;
    logic [7:0] exp_miso;
  } vec_t;

  int         n_pass = 0;
  int         n_total = 0;
  int         we_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] we_data = 8'h00;
  logic [7:0] model_wdata = 8'h00;

  // Count strobe cycles so pulse widths show up as counts.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.we) begin
        we_cnt  <= we_cnt + 1;
        we_data <= bus.wdata;
      end
      if (bus.frame_err) err_cnt <= err_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Host side of one frame: sck phases of 4 clks, MISO sampled just before each rise.
  task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1, input int nedges,
                           output logic [15:0] miso_bits, output logic busy_in,
                           output logic oe_in, output logic busy_out, output logic oe_out);
    logic [15:0] frame;
    frame = {b0, b1};
    miso_bits = 16'h0;
    bus.spi_cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < nedges; i++) begin
      bus.spi_mosi = (i < 16) ? frame[15-i] : 1'($urandom_range(0, 1));
      tick(4);
      if (i < 16) miso_bits[15-i] = bus.spi_miso;
      bus.spi_sck = 1'b1;
      tick(4);
      bus.spi_sck = 1'b0;
    end
    tick(4);
    busy_in = bus.busy;
    oe_in   = bus.spi_miso_oe;
    bus.spi_cs_n = 1'b1;
    tick(8);
    busy_out = bus.busy;
    oe_out   = bus.spi_miso_oe;
  endtask

  // Frame-level model: full frames (>=16 rises) with command 0x80 write byte 1,
  // command 0x00 returns the readback in byte 1, shorter frames abort.
  function automatic vec_t model_vec(input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [7:0] rd, input int nedges);
    vec_t v;
    bit   full;
    full        = (nedges >= 16);
    v.b0        = b0;
    v.b1        = b1;
    v.rd        = rd;
    v.nedges    = nedges;
    v.exp_we    = (full && b0 == 8'h80) ? 1 : 0;
    v.exp_err   = full ? 0 : 1;
    v.exp_wdata = (v.exp_we == 1) ? b1 : model_wdata;
    v.exp_miso  = (b0 == 8'h00) ? rd : 8'h00;
    return v;
  endfunction

  task automatic run_frame(input string tag, input vec_t v);
    int          we0, err0;
    logic [15:0] miso_bits;
    logic        busy_in, oe_in, busy_out, oe_out;
    we0 = we_cnt;
    err0 = err_cnt;
    bus.rdata = v.rd;
    spi_frame(v.b0, v.b1, v.nedges, miso_bits, busy_in, oe_in, busy_out, oe_out);
    check($sformatf("%s we_pulses", tag), we_cnt - we0, v.exp_we);
    check($sformatf("%s err_pulses", tag), err_cnt - err0, v.exp_err);
    check($sformatf("%s wdata", tag), bus.wdata, v.exp_wdata);
    if (v.exp_we != 0) check($sformatf("%s we_data", tag), we_data, v.exp_wdata);
    if (v.nedges >= 16) begin
      check($sformatf("%s miso_byte0", tag), miso_bits[15:8], 8'h00);
      check($sformatf("%s miso_byte1", tag), miso_bits[7:0], v.exp_miso);
      check($sformatf("%s busy_in_done", tag), busy_in, 1'b1);
    end
    check($sformatf("%s oe_in", tag), oe_in, 1'b1);
    check($sformatf("%s busy_after", tag), busy_out, 1'b0);
    check($sformatf("%s oe_after", tag), oe_out, 1'b0);
    model_wdata = v.exp_wdata;
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s we", tag), bus.we, 1'b0);
    check($sformatf("%s wdata", tag), bus.wdata, 8'h00);
    check($sformatf("%s miso", tag), bus.spi_miso, 1'b0);
    check($sformatf("%s miso_oe", tag), bus.spi_miso_oe, 1'b0);
    check($sformatf("%s frame_err", tag), bus.frame_err, 1'b0);
    check($sformatf("%s busy", tag), bus.busy, 1'b0);
  endtask

  vec_t tbl [7];

  initial begin
    // b0, b1, rdata, edges, we, err, wdata, miso byte 1
    tbl[0] = '{8'h80, 8'hA5, 8'h00, 16, 1, 0, 8'hA5, 8'h00};
    tbl[1] = '{8'h00, 8'hFF, 8'h3C, 16, 0, 0, 8'hA5, 8'h3C};
    tbl[2] = '{8'h41, 8'h12, 8'h77, 16, 0, 0, 8'hA5, 8'h00};
    tbl[3] = '{8'h80, 8'h33, 8'h00, 11, 0, 1, 8'hA5, 8'h00};
    tbl[4] = '{8'h80, 8'h5A, 8'h00, 16, 1, 0, 8'h5A, 8'h00};
    tbl[5] = '{8'h80, 8'hC3, 8'h00, 20, 1, 0, 8'hC3, 8'h00};
    tbl[6] = '{8'h00, 8'h00, 8'hA5, 8, 0, 1, 8'hC3, 8'h00};

    rst = 1'b1;
    bus.spi_sck  = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.rdata    = 8'h00;
    #12;
    check_reset_outputs("reset");
    tick(2);
    rst = 1'b0;
    tick(10);

    for (int i = 0; i < 7; i++) run_frame($sformatf("tbl%0d", i), tbl[i]);

    // Reset after 12 bits of a write frame; cs_n stays low afterwards.
    begin
      int          we0, err0;
      logic [15:0] frame;
      frame = 16'h80FF;
      we0 = we_cnt;
      bus.spi_cs_n = 1'b0;
      tick(4);
      for (int i = 0; i < 12; i++) begin
        bus.spi_mosi = frame[15-i];
        tick(4);
        bus.spi_sck = 1'b1;
        tick(4);
        bus.spi_sck = 1'b0;
      end
      rst = 1'b1;
      #2;
      check_reset_outputs("midrst");
      tick(2);
      rst = 1'b0;
      model_wdata = 8'h00;
      err0 = err_cnt;
      for (int i = 0; i < 8; i++) begin
        bus.spi_mosi = 1'b1;
        tick(4);
        bus.spi_sck = 1'b1;
        tick(4);
        bus.spi_sck = 1'b0;
        check($sformatf("midrst busy_edge%0d", i), bus.busy, 1'b0);
      end
      check("midrst no_we", we_cnt - we0, 0);
      check("midrst no_err", err_cnt - err0, 0);
      check("midrst wdata_held", bus.wdata, 8'h00);
      bus.spi_cs_n = 1'b1;
      tick(8);
      run_frame("after_rst", model_vec(8'h80, 8'h96, 8'h00, 16));
    end

    for (int i = 0; i < 12; i++) begin
      logic [7:0] b0;
      int         sel, nedges;
      sel = $urandom_range(0, 2);
      b0 = (sel == 0) ? 8'h80 : (sel == 1) ? 8'h00 : 8'($urandom_range(0, 255));
      nedges = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 16;
      run_frame($sformatf("rnd%0d", i),
                model_vec(b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), nedges));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
